// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: captures one retiring instruction from LSU, selects the GPR write value, holds it until GPR accepts.
// Optional feature macro WBU_RETIRE_CNT_EN enables the 64-bit retired-instruction counter.
module ysyx_25020037_wbu #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid,
    output logic            wbu_ready,
    input  logic [XLEN-1:0] lsu_pc,
    input  logic [RD_W-1:0] lsu_rd,
    input  logic            lsu_rf_we,
    input  logic [1:0]      lsu_res_sel,
    input  logic [XLEN-1:0] lsu_alu_res,
    input  logic [XLEN-1:0] lsu_ld_data,
    input  logic [XLEN-1:0] lsu_csr_rdata,
    input  logic [XLEN-1:0] lsu_csr_wdata,
    output logic            wbu_valid,
    input  logic            gpr_ready,
    output logic            gpr_we,
    output logic [RD_W-1:0] wbu_rd,
    output logic [XLEN:0]   wu_to_gu_bus,
    output logic [XLEN-1:0] csr_wcsr_data,
    output logic [63:0]     retire_cnt
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;
    logic            w_complete;
    logic [XLEN-1:0] w_wdata;

    logic            r_gpr_we;
    logic [RD_W-1:0] r_rd;
    logic [XLEN-1:0] r_gpr_wdata;
    logic [XLEN-1:0] r_csr_wdata;

    always_comb begin
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_accept = lsu_valid;
                if (lsu_valid) w_next_state = S_HOLD;
            end
            S_HOLD: begin
                // upstream valid is ignored here; a waiting instruction is taken next IDLE cycle
                w_complete = gpr_ready;
                if (gpr_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_wdata = '0;
        case (lsu_res_sel)
            2'b00:   w_wdata = lsu_alu_res;
            2'b01:   w_wdata = lsu_ld_data;
            2'b10:   w_wdata = lsu_pc + XLEN'(4);
            default: w_wdata = lsu_csr_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpr_we    <= 1'b0;
            r_rd        <= '0;
            r_gpr_wdata <= '0;
            r_csr_wdata <= '0;
        end else if (w_accept) begin
            r_gpr_we    <= lsu_rf_we && (lsu_rd != '0);
            r_rd        <= lsu_rd;
            r_gpr_wdata <= w_wdata;
            r_csr_wdata <= lsu_csr_wdata;
        end
    end

`ifdef WBU_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_retire_cnt <= '0;
        else if (w_complete) r_retire_cnt <= r_retire_cnt + 64'd1;
    end

    assign retire_cnt = r_retire_cnt;
`else
    logic w_unused_complete;
    assign w_unused_complete = w_complete;
    assign retire_cnt        = '0;
`endif

    assign wbu_ready     = (r_state == S_IDLE);
    assign wbu_valid     = (r_state == S_HOLD);
    assign gpr_we        = r_gpr_we;
    assign wbu_rd        = r_rd;
    assign wu_to_gu_bus  = {r_gpr_we, r_gpr_wdata};
    assign csr_wcsr_data = r_csr_wdata;

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Self-checking bench for ysyx_25020037_wbu: directed spec scenarios plus randomized traffic vs. a behavioural model.
// Retire-count expectations follow WBU_RETIRE_CNT_EN when the bench is built with it.
module tb_ysyx_25020037_wbu;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
`ifdef WBU_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            lsu_valid;
    logic            wbu_ready;
    logic [XLEN-1:0] lsu_pc;
    logic [RD_W-1:0] lsu_rd;
    logic            lsu_rf_we;
    logic [1:0]      lsu_res_sel;
    logic [XLEN-1:0] lsu_alu_res;
    logic [XLEN-1:0] lsu_ld_data;
    logic [XLEN-1:0] lsu_csr_rdata;
    logic [XLEN-1:0] lsu_csr_wdata;
    logic            wbu_valid;
    logic            gpr_ready;
    logic            gpr_we;
    logic [RD_W-1:0] wbu_rd;
    logic [XLEN:0]   wu_to_gu_bus;
    logic [XLEN-1:0] csr_wcsr_data;
    logic [63:0]     retire_cnt;

    int          checks = 0;
    int          errors = 0;
    longint unsigned model_cnt = 0;

    // expected payload of the instruction most recently handed to the DUT
    logic [XLEN:0]   exp_bus;
    logic            exp_we;
    logic [RD_W-1:0] exp_rd;
    logic [XLEN-1:0] exp_csr;

    always #5 clk = ~clk;

    ysyx_25020037_wbu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .lsu_pc(lsu_pc), .lsu_rd(lsu_rd), .lsu_rf_we(lsu_rf_we),
        .lsu_res_sel(lsu_res_sel), .lsu_alu_res(lsu_alu_res),
        .lsu_ld_data(lsu_ld_data), .lsu_csr_rdata(lsu_csr_rdata),
        .lsu_csr_wdata(lsu_csr_wdata),
        .wbu_valid(wbu_valid), .gpr_ready(gpr_ready), .gpr_we(gpr_we),
        .wbu_rd(wbu_rd), .wu_to_gu_bus(wu_to_gu_bus),
        .csr_wcsr_data(csr_wcsr_data), .retire_cnt(retire_cnt)
    );

    function automatic logic [XLEN-1:0] ref_value(input logic [1:0] sel, input logic [XLEN-1:0] pc,
            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld, input logic [XLEN-1:0] crd);
        longint unsigned p4;
        p4 = (longint'(pc) + 4) % (64'd1 << XLEN);
        case (sel)
            2'd0:    return alu;
            2'd1:    return ld;
            2'd2:    return p4[XLEN-1:0];
            default: return crd;
        endcase
    endfunction

    task automatic scramble_lsu();
        lsu_pc        = $urandom;
        lsu_rd        = RD_W'($urandom);
        lsu_rf_we     = 1'($urandom);
        lsu_res_sel   = 2'($urandom);
        lsu_alu_res   = $urandom;
        lsu_ld_data   = $urandom;
        lsu_csr_rdata = $urandom;
        lsu_csr_wdata = $urandom;
    endtask

    // Present one instruction while the DUT is idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [XLEN-1:0] pc, input logic [RD_W-1:0] rd, input logic we,
            input logic [1:0] sel, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld,
            input logic [XLEN-1:0] crd, input logic [XLEN-1:0] cwd, input logic gr);
        int n = 0;
        while (wbu_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wbu_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: wbu_ready=%b required 1", wbu_ready);
        end
        lsu_pc = pc; lsu_rd = rd; lsu_rf_we = we; lsu_res_sel = sel;
        lsu_alu_res = alu; lsu_ld_data = ld; lsu_csr_rdata = crd; lsu_csr_wdata = cwd;
        gpr_ready = gr;
        lsu_valid = 1'b1;
        exp_we  = we && (rd != 0);
        exp_bus = {exp_we, ref_value(sel, pc, alu, ld, crd)};
        exp_rd  = rd;
        exp_csr = cwd;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        scramble_lsu();
        @(negedge clk);
    endtask

    // Raise gpr_ready for one edge; returns at the following negedge.
    task automatic complete_hold();
        gpr_ready = 1'b1;
        @(posedge clk);
        #1;
        gpr_ready = 1'b0;
        model_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lsu_valid = 1'b0;
        gpr_ready = 1'b0;
        scramble_lsu();
        repeat (2) @(negedge clk);
        checks++;
        if (wbu_ready !== 1'b1 || wbu_valid !== 1'b0 || gpr_we !== 1'b0 || wbu_rd !== '0 ||
                wu_to_gu_bus !== '0 || csr_wcsr_data !== '0 || retire_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b we=%b rd=%0d bus=%h csr=%h cnt=%0d required 1 0 0 0 0 0 0",
                wbu_ready, wbu_valid, gpr_we, wbu_rd, wu_to_gu_bus, csr_wcsr_data, retire_cnt);
        end
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_alu_first();
        issue(32'h8000_0000, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h55, 1'b1);
        checks++;
        if (wbu_valid !== 1'b1 || wu_to_gu_bus !== 33'h1_0000_1234 || wbu_rd !== 5'd5) begin
            errors++;
            $display("FAIL alu_payload: valid=%b bus=%h rd=%0d required 1 100001234 5", wbu_valid, wu_to_gu_bus, wbu_rd);
        end
        @(posedge clk);
        #1;
        gpr_ready = 1'b0;
        model_cnt++;
        @(negedge clk);
        checks++;
        if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_return_idle: valid=%b ready=%b required 0 1", wbu_valid, wbu_ready);
        end
    endtask

    task automatic test_muxes();
        issue(32'h0, 5'd10, 1'b1, 2'b01, 32'h0, 32'hFFFF_FF80, 32'h0, 32'h0, 1'b0);
        checks++;
        if (wu_to_gu_bus[XLEN-1:0] !== 32'hFFFF_FF80 || gpr_we !== 1'b1 || wu_to_gu_bus[XLEN] !== 1'b1) begin
            errors++;
            $display("FAIL load_sel: wdata=%h we=%b required ffffff80 1", wu_to_gu_bus[XLEN-1:0], gpr_we);
        end
        complete_hold();
        issue(32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
        checks++;
        if (wu_to_gu_bus[XLEN-1:0] !== 32'h0) begin
            errors++;
            $display("FAIL pc4_wrap: wdata=%h required 00000000", wu_to_gu_bus[XLEN-1:0]);
        end
        complete_hold();
        issue(32'h100, 5'd7, 1'b1, 2'b11, 32'h1, 32'h2, 32'h1800, 32'hCAFE_0088, 1'b0);
        checks++;
        if (wu_to_gu_bus[XLEN-1:0] !== 32'h1800 || csr_wcsr_data !== 32'hCAFE_0088) begin
            errors++;
            $display("FAIL csr_sel: wdata=%h csr=%h required 00001800 cafe0088", wu_to_gu_bus[XLEN-1:0], csr_wcsr_data);
        end
        complete_hold();
    endtask

    task automatic test_rd_zero();
        issue(32'h0, 5'd0, 1'b1, 2'b00, 32'hDEAD, 32'h0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (gpr_we !== 1'b0 || wu_to_gu_bus !== 33'h0_0000_DEAD || wbu_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_zero: we=%b bus=%h valid=%b required 0 00000dead 1", gpr_we, wu_to_gu_bus, wbu_valid);
        end
        complete_hold();
    endtask

    task automatic test_stall();
        issue(32'h40, 5'd9, 1'b1, 2'b00, 32'hABCD_0001, 32'h0, 32'h0, 32'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            lsu_valid = ~lsu_valid;
            scramble_lsu();
            @(negedge clk);
            checks++;
            if (wu_to_gu_bus !== exp_bus || wbu_ready !== 1'b0 || wbu_valid !== 1'b1 ||
                    wbu_rd !== exp_rd || csr_wcsr_data !== exp_csr) begin
                errors++;
                $display("FAIL stall_hold[%0d]: bus=%h ready=%b valid=%b required %h 0 1", i, wu_to_gu_bus, wbu_ready, wbu_valid, exp_bus);
            end
        end
        lsu_valid = 1'b0;
        complete_hold();
        checks++;
        if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b required 0 1", wbu_valid, wbu_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN:0] bus_b;
        issue(32'h200, 5'd3, 1'b1, 2'b00, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 1'b0);
        lsu_pc = 32'h300; lsu_rd = 5'd4; lsu_rf_we = 1'b1; lsu_res_sel = 2'b01;
        lsu_ld_data = 32'h2222_2222; lsu_csr_wdata = 32'h99;
        bus_b = {1'b1, 32'h2222_2222};
        lsu_valid = 1'b1;
        gpr_ready = 1'b1;
        @(posedge clk);
        #1;
        gpr_ready = 1'b0;
        model_cnt++;
        @(negedge clk);
        checks++;
        if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_complete_only: valid=%b ready=%b required 0 1", wbu_valid, wbu_ready);
        end
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wbu_valid !== 1'b1 || wu_to_gu_bus !== bus_b || wbu_rd !== 5'd4 || csr_wcsr_data !== 32'h99) begin
            errors++;
            $display("FAIL b2b_second: valid=%b bus=%h rd=%0d required 1 %h 4", wbu_valid, wu_to_gu_bus, wbu_rd, bus_b);
        end
        complete_hold();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [XLEN-1:0] pc, alu, ld, crd, cwd;
            logic [RD_W-1:0] rd;
            logic [1:0]      sel;
            logic            we;
            int              stall;
            pc = $urandom; alu = $urandom; ld = $urandom; crd = $urandom; cwd = $urandom;
            rd = RD_W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            sel = 2'($urandom); we = 1'($urandom);
            if (t % 8 == 0) pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            stall = $urandom_range(0, 3);
            issue(pc, rd, we, sel, alu, ld, crd, cwd, 1'b0);
            for (int s = 0; s <= stall; s++) begin
                checks++;
                if (wbu_valid !== 1'b1 || wbu_ready !== 1'b0 || wu_to_gu_bus !== exp_bus ||
                        gpr_we !== exp_we || wbu_rd !== exp_rd || csr_wcsr_data !== exp_csr) begin
                    errors++;
                    $display("FAIL rand_payload[%0d.%0d]: valid=%b bus=%h we=%b rd=%0d csr=%h required 1 %h %b %0d %h",
                        t, s, wbu_valid, wu_to_gu_bus, gpr_we, wbu_rd, csr_wcsr_data, exp_bus, exp_we, exp_rd, exp_csr);
                end
                if (s < stall) begin
                    lsu_valid = 1'($urandom);
                    scramble_lsu();
                    @(negedge clk);
                end
            end
            lsu_valid = 1'b0;
            complete_hold();
            checks++;
            if (retire_cnt !== (CNT_EN ? 64'(model_cnt) : 64'd0) || wbu_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_retire[%0d]: cnt=%0d valid=%b required %0d 0", t, retire_cnt, wbu_valid,
                    CNT_EN ? model_cnt : 0);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        issue(32'h500, 5'd12, 1'b1, 2'b00, 32'hFEED_BEEF, 32'h0, 32'h0, 32'h1234_5678, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1 || gpr_we !== 1'b0 || wbu_rd !== '0 ||
                wu_to_gu_bus !== '0 || csr_wcsr_data !== '0 || retire_cnt !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b we=%b bus=%h csr=%h cnt=%0d required 0 1 0 0 0 0",
                wbu_valid, wbu_ready, gpr_we, wu_to_gu_bus, csr_wcsr_data, retire_cnt);
        end
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(32'h600 + 32'(i * 4), 5'(i + 1), 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
            complete_hold();
        end
        checks++;
        if (retire_cnt !== (CNT_EN ? 64'd3 : 64'd0)) begin
            errors++;
            $display("FAIL retire_after_reset: cnt=%0d required %0d", retire_cnt, CNT_EN ? 3 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_alu_first();
        test_muxes();
        test_rd_zero();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
